// File: rtl/mem_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_cmd_sequencer_pkg
// Brief    : Shared key codes, FSM states and default sizing for the
//            keypad-driven memory command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mem_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        KEY_SELECT  = 2'b00,
        KEY_SET     = 2'b01,
        KEY_CLEAR   = 2'b10,
        KEY_DISPLAY = 2'b11
    } key_type_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_FIFO_DEPTH  = 4;
    localparam int unsigned DEFAULT_ACK_TIMEOUT = 15;

    // Four locations, so the increment wraps 3 -> 0 on its own.
    function automatic logic [1:0] loc_inc(input logic [1:0] loc);
        return loc + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_cmd_sequencer_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Brief    : Small synchronous command FIFO; a push is accepted when full
//            if a pop happens on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned    AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_cmd_sequencer
// Brief    : Turns keypad presses into queued commands that step the memory
//            location, update the display or run set/clear transactions.
// Revision : 1.0 - initial release
// ============================================================================
module mem_cmd_sequencer
    import mem_cmd_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       keyPress,
    input  logic [1:0] keyType,
    output logic       memReq,
    input  logic       memAck,
    output logic       memSet,
    output logic       memClr,
    output logic [1:0] memLoc,
    output logic [1:0] memDisplay,
    output logic       busy,
    output logic       drop,
    output logic       timeout
);
    localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT + 1);
    // The ISSUE cycle is the first unacknowledged request cycle, so WAIT_ACK
    // gives up after ACK_TIMEOUT-1 more.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 2);

    logic             key_prev;
    logic             key_event;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       fifo_dout;
    key_type_t        cmd;
    state_t           state;
    state_t           state_next;
    key_type_t        op;
    key_type_t        op_next;
    logic [1:0]       loc_next;
    logic [1:0]       disp_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout_next;
    logic             drop_next;

    assign key_event = keyPress && !key_prev;
    assign cmd       = key_type_t'(fifo_dout);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (key_event),
        .din   (keyType),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign memReq = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
    assign memSet = memReq && (op == KEY_SET);
    assign memClr = memReq && (op == KEY_CLEAR);
    assign busy   = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        op_next      = op;
        loc_next     = memLoc;
        disp_next    = memDisplay;
        cnt_next     = cnt;
        timeout_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    case (cmd)
                        KEY_SELECT:  loc_next  = loc_inc(memLoc);
                        KEY_DISPLAY: disp_next = memLoc;
                        default: begin
                            op_next    = cmd;
                            state_next = ST_ISSUE;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                cnt_next   = '0;
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (memAck) begin
                    state_next = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        drop_next = key_event && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev   <= 1'b0;
            state      <= ST_IDLE;
            op         <= KEY_SELECT;
            cnt        <= '0;
            memLoc     <= 2'd0;
            memDisplay <= 2'd0;
            drop       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            key_prev   <= keyPress;
            state      <= state_next;
            op         <= op_next;
            cnt        <= cnt_next;
            memLoc     <= loc_next;
            memDisplay <= disp_next;
            drop       <= drop_next;
            timeout    <= timeout_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_cmd_sequencer.md
MEM_CMD_SEQUENCER -- requirements
Module: mem_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, 4, command FIFO entries (power of two, >=2); ACK_TIMEOUT, 15, max cycles waiting for memAck.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 keyPress  input  1  key-held level from keypad, synchronous to clk.
REQ-005 keyType  input  2  key code: 00 SELECT, 01 SET, 10 CLEAR, 11 DISPLAY.
REQ-006 memReq  output  1  memory transaction request.
REQ-007 memAck  input  1  memory transaction accepted/completed.
REQ-008 memSet  output  1  store to memLoc; valid only while memReq=1.
REQ-009 memClr  output  1  clear memLoc; valid only while memReq=1.
REQ-010 memLoc  output  2  current memory location.
REQ-011 memDisplay  output  2  location shown on display.
REQ-012 busy  output  1  high when FSM is not IDLE or FIFO is non-empty.
REQ-013 drop  output  1  one-cycle pulse: key event lost because FIFO full.
REQ-014 timeout  output  1  one-cycle pulse: transaction aborted, no memAck.

Function
REQ-015 Key event SHALL be a 0->1 transition of keyPress against its registered previous value; held key yields exactly one event.
REQ-016 On event, keyType SHALL be written into FIFO at that edge; FIFO full with no same-cycle pop -> event discarded, drop=1 next cycle.
REQ-017 Full FIFO with a pop on the same edge SHALL accept the push; push into empty FIFO SHALL NOT be popped until the following edge.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_ACK.
REQ-019 IDLE: FIFO non-empty -> pop one entry; SELECT: memLoc<=memLoc+1 mod 4 (3 wraps to 0), stay IDLE; DISPLAY: memDisplay<=memLoc, stay IDLE; SET/CLEAR: latch opcode, go ISSUE.
REQ-020 ISSUE: memReq=1 with memSet (SET) or memClr (CLEAR), go WAIT_ACK; timeout counter cleared.
REQ-021 WAIT_ACK: memReq and memSet/memClr SHALL remain stable; memAck=1 -> deassert all next cycle, go IDLE.
REQ-022 WAIT_ACK with no memAck for ACK_TIMEOUT consecutive cycles -> deassert request, timeout pulse, go IDLE, command discarded.
REQ-023 memAck SHALL be ignored when memReq=0; memSet and memClr SHALL never be high together.
REQ-024 Latency, idle system: keyPress sampled high at edge k -> FIFO write at k, pop at k+1, memReq high after k+1; SELECT/DISPLAY outputs update at k+1.
REQ-025 memLoc SHALL NOT change while memReq=1; queued SELECTs execute in order after the transaction.

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, memReq/memSet/memClr/drop/timeout/busy=0, memLoc=0, memDisplay=0, keyPress history=0.
REQ-027 Reset mid-transaction SHALL abort it without a timeout pulse; keyPress held through reset release counts as one new event.

Structure
REQ-028 Shared package SHALL hold the keyType enum (SELECT/SET/CLEAR/DISPLAY), the FSM state enum, and FIFO_DEPTH/ACK_TIMEOUT defaults.
REQ-029 Command FIFO SHALL be a sub-module, cmd_fifo (push/pop/full/empty, parameterised depth); edge detect and FSM stay in top.

Verification
REQ-030 Reset, then press SELECT 5 times -> memLoc 1,2,3,0,1; memReq never high.
REQ-031 SELECT, then SET, memAck returned 3 cycles after memReq -> memReq/memSet high 4 cycles at memLoc=1, low cycle after ack.
REQ-032 Hold memAck 0 after CLEAR -> memClr held ACK_TIMEOUT=15 cycles, timeout pulse once, FSM IDLE, busy drops.
REQ-033 Stall memAck, issue 6 events (SET then 5 SELECT) -> first popped, next 4 queued, 6th gives one drop pulse; after ack, memLoc advances 4.
REQ-034 keyPress held high 20 cycles with DISPLAY -> single event, memDisplay=memLoc once.
REQ-035 Assert rst_n low during WAIT_ACK -> memReq low asynchronously, memLoc=0, no timeout pulse, busy=0.
